psum_ofifo: RTL and testbench

- Output collector directly downstream of the MAC column array.
- Each column delivers its psum on a per-lane write strobe, taken from that column's fifo_wr. Strobes arrive staggered by one cycle per column because instructions pipeline column to column.
- The block buffers each column in an independent lane FIFO and presents one aligned row, one psum per column, to the readout/SFU stage when every lane holds data.

---
 rtl/psum_ofifo_if.sv | 26 ++
 rtl/psum_ofifo.sv | 89 ++++++++
 tb/tb_psum_ofifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/psum_ofifo_if.sv
// Handshake bundle between the MAC column array, psum_ofifo and the readout stage.
// master drives psums/strobes/pop; slave is the collector itself.
interface psum_ofifo_if #(
   parameter int unsigned col     = 8,
   parameter int unsigned bw_psum = 22
);
   logic [col*bw_psum-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [col*bw_psum-1:0] out;
   logic                   o_valid;
   logic                   o_full;
   logic                   o_ready;
   logic                   o_overflow;
   logic                   o_underflow;

   modport master (
      output in, wr, rd,
      input  out, o_valid, o_full, o_ready, o_overflow, o_underflow
   );

   modport slave (
      input  in, wr, rd,
      output out, o_valid, o_full, o_ready, o_overflow, o_underflow
   );
endinterface

// File: rtl/psum_ofifo.sv
// Output collector behind the MAC column array. One independent FIFO lane per column
// absorbs the staggered per-column psum writes; a row is popped only when every lane has
// data, so the readout stage always sees one aligned psum per column.
module psum_ofifo #(
   parameter int unsigned col      = 8,
   parameter int unsigned bw_psum  = 22,
   parameter int unsigned depth    = 16,
   parameter int unsigned lg_depth = 4
) (
   input logic        clk,
   input logic        reset,
   psum_ofifo_if.slave bus
);

   typedef logic [lg_depth:0] ptr_t;

   // Extra MSB on the pointers distinguishes full from empty when the low bits match.
   ptr_t                   wr_ptr_q [col];
   ptr_t                   rd_ptr_q [col];
   logic [bw_psum-1:0]     mem_q    [col][depth];
   logic [col*bw_psum-1:0] out_q;
   logic                   overflow_q;
   logic                   underflow_q;

   logic [col-1:0] empty;
   logic [col-1:0] full;
   logic [col-1:0] wr_acc;
   logic [col-1:0] wr_drop;
   logic           valid;
   logic           rd_acc;

   // Per-lane occupancy status and write acceptance, from pointers only.
   always_comb begin
      empty   = '0;
      full    = '0;
      wr_acc  = '0;
      wr_drop = '0;
      for (int i = 0; i < col; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][lg_depth-1:0] == rd_ptr_q[i][lg_depth-1:0]) &&
                    (wr_ptr_q[i][lg_depth] != rd_ptr_q[i][lg_depth]);
      end
      valid  = ~|empty;
      rd_acc = bus.rd & valid;
      for (int i = 0; i < col; i++) begin
         // A full lane still takes the write when the same cycle pops its head.
         wr_acc[i]  = bus.wr[i] & (~full[i] | rd_acc);
         wr_drop[i] = bus.wr[i] & full[i] & ~rd_acc;
      end
   end

   // Pointers, registered output row and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < col; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         out_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < col; i++) begin
            if (wr_acc[i]) wr_ptr_q[i] <= wr_ptr_q[i] + ptr_t'(1);
            if (rd_acc) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + ptr_t'(1);
               out_q[i*bw_psum +: bw_psum] <= mem_q[i][rd_ptr_q[i][lg_depth-1:0]];
            end
         end
         if (|wr_drop) overflow_q <= 1'b1;
         if (bus.rd && !valid) underflow_q <= 1'b1;
      end
   end

   // Lane storage; deliberately not reset, contents are qualified by the pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < col; i++) begin
         if (wr_acc[i]) mem_q[i][wr_ptr_q[i][lg_depth-1:0]] <= bus.in[i*bw_psum +: bw_psum];
      end
   end

   assign bus.out         = out_q;
   assign bus.o_valid     = valid;
   assign bus.o_full      = |full;
   assign bus.o_ready     = ~|full;
   assign bus.o_overflow  = overflow_q;
   assign bus.o_underflow = underflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: per-lane queue model, row scoreboard and a decoupled output monitor.
module tb_psum_ofifo;

   localparam int unsigned col      = 8;
   localparam int unsigned bw_psum  = 22;
   localparam int unsigned depth    = 16;
   localparam int unsigned lg_depth = 4;
   localparam int unsigned w        = col * bw_psum;

   typedef logic [w-1:0]       row_t;
   typedef logic [bw_psum-1:0] psum_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   psum_ofifo_if #(.col(col), .bw_psum(bw_psum)) bus ();

   psum_ofifo #(
      .col      (col),
      .bw_psum  (bw_psum),
      .depth    (depth),
      .lg_depth (lg_depth)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one queue per lane, expected popped rows, sticky flags.
   psum_t lane_q [col][$];
   row_t  exp_q [$];
   bit    ovf_m;
   bit    unf_m;

   task automatic check(input string name, input row_t act, input row_t req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic bit model_valid();
      for (int i = 0; i < col; i++) if (lane_q[i].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < col; i++) if (lane_q[i].size() == depth) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < col; i++) lane_q[i].delete();
      exp_q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
   endtask

   // One cycle: check status against the model, then drive inputs and advance the model.
   task automatic step(input logic [col-1:0] wm, input row_t d, input logic r);
      bit   acc;
      row_t head;
      @(negedge clk);
      check("o_valid", row_t'(bus.o_valid), row_t'(model_valid()));
      check("o_full", row_t'(bus.o_full), row_t'(model_full()));
      check("o_ready", row_t'(bus.o_ready), row_t'(!model_full()));
      check("o_overflow", row_t'(bus.o_overflow), row_t'(ovf_m));
      check("o_underflow", row_t'(bus.o_underflow), row_t'(unf_m));
      bus.wr = wm;
      bus.in = d;
      bus.rd = r;
      acc = r && model_valid();
      if (r && !acc) unf_m = 1'b1;
      if (acc) begin
         head = '0;
         for (int i = 0; i < col; i++) head[i*bw_psum +: bw_psum] = lane_q[i].pop_front();
         exp_q.push_back(head);
      end
      for (int i = 0; i < col; i++) begin
         if (wm[i]) begin
            if (lane_q[i].size() < depth) lane_q[i].push_back(d[i*bw_psum +: bw_psum]);
            else ovf_m = 1'b1;
         end
      end
   endtask

   task automatic idle();
      step('0, '0, 1'b0);
   endtask

   task automatic sync_reset();
      @(negedge clk);
      bus.wr = '0;
      bus.rd = 1'b0;
      reset  = 1'b0;
      clear_model();
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic row_t rand_row();
      row_t r;
      for (int i = 0; i < col; i++) r[i*bw_psum +: bw_psum] = psum_t'($urandom);
      return r;
   endfunction

   // Monitor: on every accepted pop, compare the registered row one cycle later.
   initial begin : monitor
      logic hs;
      forever begin
         @(posedge clk);
         hs = reset && bus.rd && bus.o_valid;
         #1;
         if (hs) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pop: got out=%0h, required no pop", bus.out);
            end else begin
               check("out_row", bus.out, exp_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      row_t d;
      bus.in = '0;
      bus.wr = '0;
      bus.rd = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check("out_at_reset", bus.out, '0);

      // 1: single aligned row
      for (int i = 0; i < col; i++) d[i*bw_psum +: bw_psum] = psum_t'(100 + i);
      step('1, d, 1'b0);
      step('0, '0, 1'b1);
      idle();
      idle();

      // 2: staggered per-lane arrival
      for (int i = 0; i < col; i++) d[i*bw_psum +: bw_psum] = psum_t'(16 * i + 1);
      for (int i = 0; i < col; i++) step(col'(1) << i, d, 1'b0);
      idle();
      step('0, '0, 1'b1);
      idle();

      // 3: fill to full, overflow on lane 0, drain in order
      sync_reset();
      for (int k = 0; k < depth; k++) begin
         d = rand_row();
         d[bw_psum-1:0] = psum_t'(k);
         step('1, d, 1'b0);
      end
      d = rand_row();
      d[bw_psum-1:0] = psum_t'(999);
      step(col'(1), d, 1'b0);
      for (int k = 0; k < depth; k++) step('0, '0, 1'b1);
      idle();
      idle();

      // 4: full lanes with simultaneous write and pop, across pointer wrap
      sync_reset();
      for (int k = 0; k < depth; k++) step('1, rand_row(), 1'b0);
      for (int k = 0; k < 40; k++) step('1, rand_row(), 1'b1);
      for (int k = 0; k < depth; k++) step('0, '0, 1'b1);
      idle();
      idle();

      // 5: underflow from empty, then normal traffic
      sync_reset();
      step('0, '0, 1'b1);
      idle();
      check("out_after_underflow", bus.out, '0);
      step('1, rand_row(), 1'b0);
      step('0, '0, 1'b1);
      idle();
      idle();

      // 6: asynchronous reset mid-cycle with data loaded
      sync_reset();
      for (int k = 0; k < 5; k++) step('1, rand_row(), 1'b0);
      step('0, '0, 1'b1);
      step('1, rand_row(), 1'b0);
      @(posedge clk);
      #3;
      bus.wr = '0;
      bus.rd = 1'b0;
      reset  = 1'b0;
      #1;
      check("async_o_valid", row_t'(bus.o_valid), '0);
      check("async_o_full", row_t'(bus.o_full), '0);
      check("async_o_ready", row_t'(bus.o_ready), row_t'(1));
      check("async_out", bus.out, '0);
      check("async_o_overflow", row_t'(bus.o_overflow), '0);
      check("async_o_underflow", row_t'(bus.o_underflow), '0);
      clear_model();
      @(negedge clk);
      reset = 1'b1;
      step('1, rand_row(), 1'b0);
      step('0, '0, 1'b1);
      idle();
      idle();

      // 7: random lane masks and pops
      sync_reset();
      for (int k = 0; k < 400; k++) begin
         step(col'($urandom_range(0, 255)), rand_row(), ($urandom_range(0, 99) < 35));
      end
      bus.rd = 1'b0;
      for (int k = 0; k < depth + 2; k++) step('0, '0, 1'b1);
      idle();
      idle();

      check("scoreboard_drained", row_t'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

endmodule
